// File: rtl/toast_imem_loader.sv
// Instruction-memory loader: turns RAW / LI / END commands into IMEM writes and holds the core in reset until END.
// Optional single-word LI expansion is enabled by defining TOAST_LI_COMPRESS_EN.
module toast_imem_loader #(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int BASE_ADDR  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [4:0]        i_cmd_rd,
  input  logic [31:0]       i_cmd_data,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);

`ifdef TOAST_LI_COMPRESS_EN
  localparam bit LI_COMPRESS = 1'b1;
`else
  localparam bit LI_COMPRESS = 1'b0;
`endif

  localparam logic [1:0]        OP_LI      = 2'b01;
  localparam logic [1:0]        OP_END     = 2'b10;
  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {IDLE, WR_RAW, WR_LUI, WR_ADDI, DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              write_state;
  logic              full;
  logic              commit;
  logic [19:0]       li_hi;
  logic              li_k_zero;
  logic              li_lo_zero;

  // Upper 20 bits of k = imm - sext(imm[11:0]); the low 12 bits of k are always
  // zero, so k[31:12] is imm[31:12] plus one when the low immediate is negative.
  function automatic logic [19:0] li_upper(input logic [31:0] imm);
    return imm[31:12] + {19'd0, imm[11]};
  endfunction

  assign li_hi      = li_upper(data_q);
  assign li_k_zero  = LI_COMPRESS && (li_hi == 20'd0);
  assign li_lo_zero = LI_COMPRESS && (data_q[11:0] == 12'd0);
  assign full       = (count_q == FULL_COUNT);

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
    state_d = state_q;
    rd_d    = rd_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          rd_d   = i_cmd_rd;
          data_d = i_cmd_data;
          if (i_cmd_op == OP_END) begin
            state_d = DONE;
          end else if (i_cmd_op == OP_LI) begin
            state_d = (LI_COMPRESS && (li_upper(i_cmd_data) == 20'd0)) ? WR_ADDI : WR_LUI;
          end else begin
            state_d = WR_RAW;
          end
        end
      end
      WR_RAW:  state_d = IDLE;
      WR_LUI:  state_d = li_lo_zero ? IDLE : WR_ADDI;
      WR_ADDI: state_d = IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_state  = (state_q == WR_RAW) || (state_q == WR_LUI) || (state_q == WR_ADDI);
    commit       = write_state && !full;
    o_imem_wdata = 32'd0;
    case (state_q)
      WR_RAW:  o_imem_wdata = data_q;
      WR_LUI:  o_imem_wdata = {li_hi, rd_q, 7'b0110111};
      WR_ADDI: o_imem_wdata = {data_q[11:0], (li_k_zero ? 5'd0 : rd_q), 3'b000, rd_q, 7'b0010011};
      default: o_imem_wdata = 32'd0;
    endcase

    addr_d     = addr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (commit) begin
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(1);
    end
    if (write_state && full) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rd_q       <= 5'd0;
      data_q     <= 32'd0;
      addr_q     <= BASE;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_imem_we    = commit;
  assign o_imem_addr  = addr_q;
  assign o_core_rst   = (state_q != DONE);
  assign o_done       = (state_q == DONE);
  assign o_overflow   = overflow_q;
  assign o_word_count = count_q;

endmodule

// File: tb/tb_toast_imem_loader.sv
// Scoreboard bench for toast_imem_loader: a 1024-word instance for function/random tests and a 4-word one for overflow.
module tb_toast_imem_loader;

  localparam int DEPTH_A = 1024;
  localparam int AW_A    = 10;
  localparam int DEPTH_B = 4;
  localparam int AW_B    = 2;

`ifdef TOAST_LI_COMPRESS_EN
  localparam bit COMPRESS = 1'b1;
`else
  localparam bit COMPRESS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_valid, a_ready, a_we, a_core_rst, a_done, a_ovf;
  logic [1:0]      a_op;
  logic [4:0]      a_rd;
  logic [31:0]     a_data, a_wdata;
  logic [AW_A-1:0] a_addr;
  logic [AW_A:0]   a_cnt;

  logic            b_rst, b_valid, b_ready, b_we, b_core_rst, b_done, b_ovf;
  logic [1:0]      b_op;
  logic [4:0]      b_rd;
  logic [31:0]     b_data, b_wdata;
  logic [AW_B-1:0] b_addr;
  logic [AW_B:0]   b_cnt;

  toast_imem_loader #(.IMEM_DEPTH(DEPTH_A)) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_cmd_valid(a_valid), .o_cmd_ready(a_ready),
    .i_cmd_op(a_op), .i_cmd_rd(a_rd), .i_cmd_data(a_data),
    .o_imem_we(a_we), .o_imem_addr(a_addr), .o_imem_wdata(a_wdata),
    .o_core_rst(a_core_rst), .o_done(a_done), .o_overflow(a_ovf), .o_word_count(a_cnt)
  );

  toast_imem_loader #(.IMEM_DEPTH(DEPTH_B)) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_cmd_valid(b_valid), .o_cmd_ready(b_ready),
    .i_cmd_op(b_op), .i_cmd_rd(b_rd), .i_cmd_data(b_data),
    .o_imem_we(b_we), .o_imem_addr(b_addr), .o_imem_wdata(b_wdata),
    .o_core_rst(b_core_rst), .o_done(b_done), .o_overflow(b_ovf), .o_word_count(b_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_count[2];
  bit   m_ovf[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an expected write lands at (count mod 2^ADDR_W) while the memory has room.
  task automatic emit(input int inst, input logic [31:0] word);
    exp_t e;
    int depth;
    int aw;
    depth = (inst == 0) ? DEPTH_A : DEPTH_B;
    aw    = (inst == 0) ? AW_A : AW_B;
    if (m_count[inst] < depth) begin
      e.addr = 32'(m_count[inst] % (1 << aw));
      e.data = word;
      if (inst == 0) q_a.push_back(e);
      else           q_b.push_back(e);
      m_count[inst]++;
    end else begin
      m_ovf[inst] = 1'b1;
    end
  endtask

  task automatic model_li(input int inst, input logic [4:0] rd, input logic [31:0] imm, output int lat);
    logic [31:0] m;
    logic [31:0] k;
    m = {{20{imm[11]}}, imm[11:0]};
    k = imm - m;
    if (COMPRESS && k == 32'd0) begin
      emit(inst, {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011});
      lat = 2;
    end else if (COMPRESS && imm[11:0] == 12'd0) begin
      emit(inst, {k[31:12], rd, 7'b0110111});
      lat = 2;
    end else begin
      emit(inst, {k[31:12], rd, 7'b0110111});
      emit(inst, {imm[11:0], rd, 3'b000, rd, 7'b0010011});
      lat = 3;
    end
  endtask

  function automatic logic ready_of(input int inst);
    return (inst == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic [31:0] ctrl_of(input int inst);
    return (inst == 0) ? 32'({a_ready, a_we, a_core_rst, a_done, a_ovf})
                       : 32'({b_ready, b_we, b_core_rst, b_done, b_ovf});
  endfunction

  function automatic logic [31:0] cnt_of(input int inst);
    return (inst == 0) ? 32'(a_cnt) : 32'(b_cnt);
  endfunction

  function automatic logic [31:0] addr_of(input int inst);
    return (inst == 0) ? 32'(a_addr) : 32'(b_addr);
  endfunction

  function automatic logic [31:0] wdata_of(input int inst);
    return (inst == 0) ? a_wdata : b_wdata;
  endfunction

  task automatic set_in(input int inst, input logic v, input logic [1:0] op,
                        input logic [4:0] rd, input logic [31:0] data);
    if (inst == 0) begin
      a_valid = v; a_op = op; a_rd = rd; a_data = data;
    end else begin
      b_valid = v; b_op = op; b_rd = rd; b_data = data;
    end
  endtask

  // Issue one non-END command and check the cycles from accept until ready returns.
  task automatic issue(input int inst, input logic [1:0] op, input logic [4:0] rd,
                       input logic [31:0] data, input int exp_lat);
    int waits;
    int lat;
    @(posedge clk); #1;
    set_in(inst, 1'b1, op, rd, data);
    @(negedge clk);
    waits = 0;
    while (!ready_of(inst) && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 10) check($sformatf("accept_timeout[%0d]", inst), 32'(ready_of(inst)), 32'd1);
    @(posedge clk); #1;
    set_in(inst, 1'b0, 2'b00, 5'd0, 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready_of(inst) && lat < 10);
    check($sformatf("ready_latency[%0d] op=%0d", inst, op), 32'(lat), 32'(exp_lat));
  endtask

  // {ready, we, core_rst, done, overflow} = 10100 plus zeroed counters.
  task automatic check_reset(input int inst);
    check($sformatf("rst_ctrl[%0d]", inst), ctrl_of(inst), 32'h14);
    check($sformatf("rst_count[%0d]", inst), cnt_of(inst), 32'd0);
    check($sformatf("rst_addr[%0d]", inst), addr_of(inst), 32'd0);
    check($sformatf("rst_wdata[%0d]", inst), wdata_of(inst), 32'd0);
  endtask

  task automatic reset_inst(input int inst);
    @(negedge clk);
    if (inst == 0) begin
      check("a_pending_before_reset", 32'(q_a.size()), 32'd0);
      q_a.delete();
      a_rst = 1'b1;
    end else begin
      check("b_pending_before_reset", 32'(q_b.size()), 32'd0);
      q_b.delete();
      b_rst = 1'b1;
    end
    m_count[inst] = 0;
    m_ovf[inst]   = 1'b0;
    repeat (2) @(negedge clk);
    if (inst == 0) a_rst = 1'b0;
    else           b_rst = 1'b0;
  endtask

  exp_t ea, eb;
  always @(negedge clk) begin
    if (a_we) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_write", 32'(a_we), 32'd0);
      end else begin
        ea = q_a.pop_front();
        check("a_write_addr", 32'(a_addr), ea.addr);
        check("a_write_data", a_wdata, ea.data);
      end
    end
    if (b_we) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_write", 32'(b_we), 32'd0);
      end else begin
        eb = q_b.pop_front();
        check("b_write_addr", 32'(b_addr), eb.addr);
        check("b_write_data", b_wdata, eb.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          sel;
    int          pat;
    int          seen;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] x;

    a_rst = 1'b1;
    b_rst = 1'b1;
    set_in(0, 1'b0, 2'b00, 5'd0, 32'd0);
    set_in(1, 1'b0, 2'b00, 5'd0, 32'd0);
    m_count[0] = 0; m_count[1] = 0;
    m_ovf[0]   = 1'b0; m_ovf[1] = 1'b0;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    check_reset(0);
    check_reset(1);
    repeat (5) @(negedge clk);

    // LI x5, 0x12345FFF from address 0
    emit(0, 32'h123462B7);
    emit(0, 32'hFFF28293);
    issue(0, 2'b01, 5'd5, 32'h12345FFF, 3);
    check("li_x5_count", cnt_of(0), 32'd2);
    check("li_x5_ready", 32'(a_ready), 32'd1);

    // LI x1, 0x800: negative low immediate, two words in every build
    emit(0, 32'h000010B7);
    emit(0, 32'h80008093);
    issue(0, 2'b01, 5'd1, 32'h00000800, 3);

    // LI x2, 0x7FF: k == 0
    reset_inst(0);
`ifdef TOAST_LI_COMPRESS_EN
    emit(0, 32'h7FF00113);
    issue(0, 2'b01, 5'd2, 32'h000007FF, 2);
    check("li_7ff_count", cnt_of(0), 32'd1);
`else
    emit(0, 32'h00000137);
    emit(0, 32'h7FF10113);
    issue(0, 2'b01, 5'd2, 32'h000007FF, 3);
    check("li_7ff_count", cnt_of(0), 32'd2);
`endif

    // Randomised RAW / reserved / LI mix against the model
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 2));
      pat = int'($urandom_range(0, 3));
      rd  = 5'($urandom);
      x   = $urandom;
      case (pat)
        1:       imm = {{20{x[11]}}, x[11:0]};
        2:       imm = x & 32'hFFFF_F000;
        default: imm = x;
      endcase
      if (sel == 1) begin
        model_li(0, rd, imm, lat);
        issue(0, 2'b01, rd, imm, lat);
      end else begin
        emit(0, imm);
        issue(0, (sel == 0) ? 2'b00 : 2'b11, rd, imm, 2);
      end
    end
    check("rand_count", cnt_of(0), 32'(m_count[0]));
    check("rand_addr", addr_of(0), 32'(m_count[0] % DEPTH_A));
    check("rand_overflow", 32'(a_ovf), 32'(m_ovf[0]));

    // Reset asserted while the LUI is on the write port
    reset_inst(0);
    emit(0, 32'hCAFE0013);
    issue(0, 2'b00, 5'd0, 32'hCAFE0013, 2);
    @(posedge clk); #1;
    set_in(0, 1'b1, 2'b01, 5'd3, 32'h12345678);
    @(negedge clk);
    @(posedge clk); #1;
    set_in(0, 1'b0, 2'b00, 5'd0, 32'd0);
    check("lui_we_before_reset", 32'(a_we), 32'd1);
    #2 a_rst = 1'b1;
    #1 check_reset(0);
    m_count[0] = 0;
    m_ovf[0]   = 1'b0;
    repeat (2) @(negedge clk);
    a_rst = 1'b0;

    // RAW then END; a following command is held but never accepted
    reset_inst(0);
    emit(0, 32'h00000013);
    issue(0, 2'b00, 5'd0, 32'h00000013, 2);
    @(posedge clk); #1;
    set_in(0, 1'b1, 2'b10, 5'd0, 32'd0);
    @(negedge clk);
    check("end_accept_ready", 32'(a_ready), 32'd1);
    @(posedge clk); #1;
    set_in(0, 1'b1, 2'b00, 5'd7, 32'hDEADBEEF);
    @(negedge clk);
    check("end_ctrl", ctrl_of(0), 32'h02);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_ready) seen++;
    end
    check("end_no_accept", 32'(seen), 32'd0);
    check("end_count", cnt_of(0), 32'd1);
    check("end_done_held", 32'(a_done), 32'd1);
    set_in(0, 1'b0, 2'b00, 5'd0, 32'd0);

    // Depth-4 instance: three RAWs, then an LI whose ADDI does not fit
    for (int i = 0; i < 3; i++) begin
      x = $urandom;
      emit(1, x);
      issue(1, 2'b00, 5'd0, x, 2);
    end
    check("b_count_3", cnt_of(1), 32'd3);
    check("b_ovf_before", 32'(b_ovf), 32'd0);
    emit(1, 32'h123462B7);
    emit(1, 32'hFFF28293);
    issue(1, 2'b01, 5'd5, 32'h12345FFF, 3);
    check("b_ovf_after_li", 32'(b_ovf), 32'd1);
    check("b_count_full", cnt_of(1), 32'd4);
    check("b_addr_wrapped", addr_of(1), 32'd0);
    emit(1, 32'h00100093);
    issue(1, 2'b00, 5'd0, 32'h00100093, 2);
    check("b_count_still_full", cnt_of(1), 32'd4);
    check("b_ovf_sticky", 32'(b_ovf), 32'(m_ovf[1]));

    repeat (4) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
